// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed N-digit hex display driver with frame-synchronous loading, per-digit blanking and PWM dimming.
// Optional leading-zero suppression is enabled by defining SEVSEG_LEADING_ZERO_BLANK_EN.
module seven_segment_scan_controller #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    value_load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic                    load_pending,
  output logic                    frame_done,
  output logic                    a,
  output logic                    b,
  output logic                    c,
  output logic                    d,
  output logic                    e,
  output logic                    f,
  output logic                    g,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]    SCAN_LAST     = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    SCAN_PRE_LAST = CNT_W'(REFRESH_DIV - 2);
  localparam logic [IDX_W-1:0]    IDX_LAST      = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] PWM_LAST      = BRIGHT_W'((1 << BRIGHT_W) - 2);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'b0000001;
      4'h1:    hex_to_seg = 7'b1001111;
      4'h2:    hex_to_seg = 7'b0010010;
      4'h3:    hex_to_seg = 7'b0000110;
      4'h4:    hex_to_seg = 7'b1001100;
      4'h5:    hex_to_seg = 7'b0100100;
      4'h6:    hex_to_seg = 7'b0100000;
      4'h7:    hex_to_seg = 7'b0001111;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0000100;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b1100000;
      4'hC:    hex_to_seg = 7'b0110001;
      4'hD:    hex_to_seg = 7'b1000010;
      4'hE:    hex_to_seg = 7'b0110000;
      4'hF:    hex_to_seg = 7'b0111000;
      default: hex_to_seg = 7'b1111111;
    endcase
  endfunction

  logic [CNT_W-1:0]        scan_cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [BRIGHT_W-1:0]     pwm_cnt_r;
  logic                    frame_done_r;
  logic [4*NUM_DIGITS-1:0] shadow_val_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;
  logic [NUM_DIGITS-1:0]   shadow_blank_r;
  logic [4*NUM_DIGITS-1:0] active_val_r;
  logic [NUM_DIGITS-1:0]   active_dp_r;
  logic [NUM_DIGITS-1:0]   active_blank_r;
  logic                    load_pending_r;
  logic [NUM_DIGITS-1:0]   anode_r;
  logic [6:0]              seg_r;
  logic                    dp_r;

  logic [NUM_DIGITS-1:0]   lz_s;
  logic                    show_s;
  logic [3:0]              nib_s;
  logic [NUM_DIGITS-1:0]   anode_nxt_s;
  logic [6:0]              seg_nxt_s;
  logic                    dp_nxt_s;

  // Scan/PWM timebase; frame_done is raised for the last cycle of the last digit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_r   <= {CNT_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      pwm_cnt_r    <= {BRIGHT_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      if (scan_cnt_r == SCAN_LAST) begin
        scan_cnt_r <= {CNT_W{1'b0}};
        idx_r      <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1'b1);
      end else begin
        scan_cnt_r <= scan_cnt_r + CNT_W'(1'b1);
      end
      pwm_cnt_r    <= (pwm_cnt_r == PWM_LAST) ? {BRIGHT_W{1'b0}} : pwm_cnt_r + BRIGHT_W'(1'b1);
      frame_done_r <= (scan_cnt_r == SCAN_PRE_LAST) && (idx_r == IDX_LAST);
    end
  end

  // Shadow capture; commit to the active set only at the frame boundary so a frame never mixes values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_val_r   <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r    <= {NUM_DIGITS{1'b0}};
      shadow_blank_r <= {NUM_DIGITS{1'b0}};
      active_val_r   <= {(4*NUM_DIGITS){1'b0}};
      active_dp_r    <= {NUM_DIGITS{1'b0}};
      active_blank_r <= {NUM_DIGITS{1'b0}};
      load_pending_r <= 1'b0;
    end else begin
      if (frame_done_r) begin
        active_val_r   <= shadow_val_r;
        active_dp_r    <= shadow_dp_r;
        active_blank_r <= shadow_blank_r;
      end
      if (value_load) begin
        shadow_val_r   <= value_in;
        shadow_dp_r    <= dp_in;
        shadow_blank_r <= blank_in;
        load_pending_r <= 1'b1;
      end else if (frame_done_r) begin
        load_pending_r <= 1'b0;
      end
    end
  end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  // A digit is suppressed when it and every digit above it is zero, unless its dp is set; digit 0 always shows
  always_comb begin
    logic upper_zero_s;
    lz_s         = {NUM_DIGITS{1'b0}};
    upper_zero_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero_s = upper_zero_s & (active_val_r[4*i +: 4] == 4'h0);
      lz_s[i]      = upper_zero_s & ~active_dp_r[i] & (i != 0);
    end
  end
`else
  assign lz_s = {NUM_DIGITS{1'b0}};
`endif

  // Pin values for the selected digit; dark whenever PWM is off or the digit is blanked
  always_comb begin
    anode_nxt_s = {NUM_DIGITS{1'b1}};
    seg_nxt_s   = 7'b1111111;
    dp_nxt_s    = 1'b1;
    nib_s       = active_val_r[{idx_r, 2'b00} +: 4];
    show_s      = (pwm_cnt_r < brightness) & ~active_blank_r[idx_r] & ~lz_s[idx_r];
    if (show_s) begin
      anode_nxt_s[idx_r] = 1'b0;
      seg_nxt_s          = hex_to_seg(nib_s);
      dp_nxt_s           = ~active_dp_r[idx_r];
    end else begin
      anode_nxt_s = {NUM_DIGITS{1'b1}};
      seg_nxt_s   = 7'b1111111;
      dp_nxt_s    = 1'b1;
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode_r <= {NUM_DIGITS{1'b1}};
      seg_r   <= 7'b1111111;
      dp_r    <= 1'b1;
    end else begin
      anode_r <= anode_nxt_s;
      seg_r   <= seg_nxt_s;
      dp_r    <= dp_nxt_s;
    end
  end

  assign a            = seg_r[6];
  assign b            = seg_r[5];
  assign c            = seg_r[4];
  assign d            = seg_r[3];
  assign e            = seg_r[2];
  assign f            = seg_r[1];
  assign g            = seg_r[0];
  assign dp           = dp_r;
  assign anode        = anode_r;
  assign load_pending = load_pending_r;
  assign frame_done   = frame_done_r;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: cycle-count reference model plus directed literal checks.
// Leading-zero checks run only when SEVSEG_LEADING_ZERO_BLANK_EN is defined.
module tb_seven_segment_scan_controller;

  localparam int N     = 8;
  localparam int DIV   = 4;
  localparam int BW    = 4;
  localparam int FRAME = N * DIV;
  localparam int PWM_P = (1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [4*N-1:0] value_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  blank_in = '0;
  logic          value_load = 1'b0;
  logic [BW-1:0] brightness = 4'hF;
  logic          load_pending, frame_done;
  logic          a, b, c, d, e, f, g, dp;
  logic [N-1:0]  anode;
  logic [6:0]    seg;

  assign seg = {a, b, c, d, e, f, g};

  seven_segment_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BRIGHT_W(BW)) dut (
    .clk(clk), .reset(rst_n), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
    .value_load(value_load), .brightness(brightness), .load_pending(load_pending),
    .frame_done(frame_done), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .anode(anode));

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the display is a pure function of cycles since reset and the committed value
  logic [6:0] segtab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  int           m_edges = 0;
  logic [4*N-1:0] m_sh_val = '0, m_ac_val = '0;
  logic [N-1:0] m_sh_dp = '0, m_ac_dp = '0, m_sh_bl = '0, m_ac_bl = '0;
  logic         m_pending = 1'b0;
  logic [N-1:0] e_anode = '1;
  logic [6:0]   e_seg = 7'h7F;
  logic         e_dp = 1'b1, e_fd = 1'b0, e_pending = 1'b0;

  function automatic logic suppressed(input int j);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    int msd = 0;
    for (int i = 0; i < N; i++) if (m_ac_val[4*i +: 4] != 4'h0) msd = i;
    return (j > msd) && !m_ac_dp[j];
`else
    return (j < 0);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int t, idx, pwm;
    logic show, fend;
    if (!rst_n) begin
      m_edges = 0; m_sh_val = '0; m_ac_val = '0; m_sh_dp = '0; m_ac_dp = '0;
      m_sh_bl = '0; m_ac_bl = '0; m_pending = 0;
      e_anode = '1; e_seg = 7'h7F; e_dp = 1; e_fd = 0; e_pending = 0;
    end else begin
      t = m_edges; idx = (t / DIV) % N; pwm = t % PWM_P;
      show = (pwm < int'(brightness)) && !m_ac_bl[idx] && !suppressed(idx);
      if (show) begin
        e_anode = ~(8'b1 << idx); e_seg = segtab[m_ac_val[4*idx +: 4]]; e_dp = ~m_ac_dp[idx];
      end else begin
        e_anode = '1; e_seg = 7'h7F; e_dp = 1;
      end
      fend = (t % FRAME) == FRAME - 1;
      if (fend) begin m_ac_val = m_sh_val; m_ac_dp = m_sh_dp; m_ac_bl = m_sh_bl; end
      if (value_load) begin
        m_sh_val = value_in; m_sh_dp = dp_in; m_sh_bl = blank_in; m_pending = 1;
      end else if (fend) m_pending = 0;
      e_fd = ((t + 1) % FRAME) == FRAME - 1;
      e_pending = m_pending;
      m_edges++;
    end
  end

  always @(negedge clk) begin
    check("model_anode", anode, e_anode);
    check("model_seg", seg, e_seg);
    check("model_dp", dp, e_dp);
    check("model_frame_done", frame_done, e_fd);
    check("model_load_pending", load_pending, e_pending);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] v, input logic [7:0] dpv, input logic [7:0] bl);
    value_in = v; dp_in = dpv; blank_in = bl; value_load = 1'b1;
    @(negedge clk);
    value_load = 1'b0;
  endtask

  task automatic wait_fd();
    bit ok = 0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) ok = 1;
    end
    check("wait_frame_done", ok, 1);
  endtask

  task automatic wait_anode(input logic [N-1:0] tgt);
    bit ok = 0;
    for (int i = 0; i < 3 * FRAME && !ok; i++) begin
      @(negedge clk);
      if (anode === tgt) ok = 1;
    end
    check("wait_anode", ok, 1);
  endtask

  task automatic sweep(input int n, output logic [N-1:0] seen);
    seen = '0;
    repeat (n) begin
      @(negedge clk);
      seen |= ~anode;
    end
  endtask

  initial begin
    int cnt;
    logic [N-1:0] seen;
    #2 rst_n = 1'b0;
    cyc(3);
    check("reset_anode", anode, 8'hFF);
    check("reset_seg", seg, 7'h7F);
    rst_n = 1'b1;
    // Scan order and frame rate after reset
    @(negedge clk);
    check("scan_d0_anode", anode, 8'hFE);
    check("scan_d0_seg", seg, 7'b0000001);
    cyc(4);
    check("scan_d1_anode", anode, 8'hFD);
    cnt = 0;
    repeat (64) begin @(negedge clk); if (frame_done) cnt++; end
    check("frame_done_per_64", cnt, 2);

    // Frame-synchronous load
    load(32'hFEDCBA98, 8'h00, 8'h00);
    check("load_pending_set", load_pending, 1);
    check("old_value_held", seg, 7'b0000001);
    wait_fd();
    cyc(1);
    check("load_pending_clear", load_pending, 0);
    wait_anode(8'hFE);
    check("digit0_is_8", seg, 7'b0000000);
    wait_anode(8'h7F);
    check("digit7_is_F", seg, 7'b0111000);

    // Load colliding with the frame boundary
    cyc(8);
    load(32'h11111111, 8'h00, 8'h00);
    wait_fd();
    load(32'h12345678, 8'h00, 8'h00);
    check("collision_pending", load_pending, 1);
    wait_anode(8'hFE);
    check("collision_old_shadow", seg, 7'b1001111);
    wait_fd();
    cyc(1);
    check("collision_pending_clear", load_pending, 0);
    wait_anode(8'hFE);
    check("collision_new_value", seg, 7'b0000000);

    // Brightness and blanking
    brightness = 4'd0;
    cnt = 0;
    repeat (40) begin @(negedge clk); if (anode !== 8'hFF) cnt++; end
    check("bright0_dark", cnt, 0);
    brightness = 4'd5;
    cyc(2);
    cnt = 0;
    repeat (15) begin @(negedge clk); if (anode !== 8'hFF) cnt++; end
    check("bright5_duty", cnt, 5);
    brightness = 4'hF;
    load(32'h12345678, 8'h00, 8'h01);
    wait_fd();
    cyc(1);
    sweep(FRAME, seen);
    check("blank_digit0", seen, 8'hFE);
    load(32'h12345678, 8'h00, 8'h00);
    wait_fd();
    cyc(2);

    // Asynchronous reset mid-scan discards the pending load
    wait_anode(8'hFE);
    load(32'h0000ABCD, 8'h00, 8'h00);
    wait_anode(8'hF7);
    #2 rst_n = 1'b0;
    #1;
    check("async_anode", anode, 8'hFF);
    check("async_seg", seg, 7'h7F);
    check("async_dp", dp, 1);
    check("async_pending", load_pending, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_anode", anode, 8'hFE);
    check("restart_seg", seg, 7'b0000001);
    wait_fd();
    wait_anode(8'hFE);
    check("discarded_load", seg, 7'b0000001);

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    load(32'h00000A05, 8'h00, 8'h00);
    wait_fd();
    cyc(1);
    sweep(FRAME, seen);
    check("lz_A05_digits", seen, 8'h07);
    load(32'h00000000, 8'h00, 8'h00);
    wait_fd();
    cyc(1);
    sweep(FRAME, seen);
    check("lz_zero_digits", seen, 8'h01);
    load(32'h00000000, 8'h20, 8'h00);
    wait_fd();
    cyc(1);
    sweep(FRAME, seen);
    check("lz_dp5_digits", seen, 8'h21);
    wait_anode(8'hDF);
    check("lz_dp5_seg", seg, 7'b0000001);
    check("lz_dp5_dp", dp, 0);
`endif

    cyc(4);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
